// File: rtl/avl_rr_arbiter_2m1s.sv
// Two-master, one-slave Avalon-style arbiter: round-robin request grant, zero-latency
// muxing, and an in-order ID FIFO that routes pipelined read responses to their issuer.
module avl_rr_arbiter_2m1s #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int RD_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rest,
  input  logic [AW-1:0] m0_address,
  input  logic          m0_write,
  input  logic          m0_read,
  input  logic [DW-1:0] m0_write_data,
  output logic          m0_request_ready,
  output logic [DW-1:0] m0_read_data,
  output logic          m0_read_data_valid,
  input  logic [AW-1:0] m1_address,
  input  logic          m1_write,
  input  logic          m1_read,
  input  logic [DW-1:0] m1_write_data,
  output logic          m1_request_ready,
  output logic [DW-1:0] m1_read_data,
  output logic          m1_read_data_valid,
  output logic [AW-1:0] s_address,
  output logic          s_write,
  output logic          s_read,
  output logic [DW-1:0] s_write_data,
  input  logic          s_request_ready,
  input  logic [DW-1:0] s_read_data,
  input  logic          s_read_data_valid,
  output logic          rsp_err
);

  localparam int PW = $clog2(RD_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(RD_DEPTH);

  logic [RD_DEPTH-1:0] id_mem_q;
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [PW:0]         count_q, count_d;
  logic                rr_last_q, rr_last_d;
  logic                rsp_err_q, rsp_err_d;

  logic fifo_full, fifo_empty, elig0, elig1, gnt0, gnt1;
  logic hs, push, pop, head_id;

  always_comb begin
    fifo_full  = (count_q == FULL_CNT);
    fifo_empty = (count_q == '0);
    // A full ID FIFO only blocks pure reads; writes never need a response slot.
    elig0 = m0_write | (m0_read & ~fifo_full);
    elig1 = m1_write | (m1_read & ~fifo_full);
    if (elig0 && elig1) begin
      gnt0 = rr_last_q;
      gnt1 = ~rr_last_q;
    end else begin
      gnt0 = elig0;
      gnt1 = elig1;
    end

    if (gnt1) begin
      s_address    = m1_address;
      s_write_data = m1_write_data;
      s_write      = m1_write;
      s_read       = m1_read & ~m1_write;
    end else if (gnt0) begin
      s_address    = m0_address;
      s_write_data = m0_write_data;
      s_write      = m0_write;
      s_read       = m0_read & ~m0_write;
    end else begin
      s_address    = m0_address;
      s_write_data = m0_write_data;
      s_write      = 1'b0;
      s_read       = 1'b0;
    end

    m0_request_ready = gnt0 & s_request_ready;
    m1_request_ready = gnt1 & s_request_ready;
    hs   = (gnt0 | gnt1) & s_request_ready;
    push = hs & s_read;

    head_id            = id_mem_q[rd_ptr_q];
    pop                = s_read_data_valid & ~fifo_empty;
    m0_read_data_valid = pop & ~head_id;
    m1_read_data_valid = pop & head_id;

    wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    rr_last_d = hs ? gnt1 : rr_last_q;
    rsp_err_d = rsp_err_q | (s_read_data_valid & fifo_empty);
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  assign m0_read_data = s_read_data;
  assign m1_read_data = s_read_data;
  assign rsp_err      = rsp_err_q;

  // ID storage holds no reset; occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      id_mem_q[wr_ptr_q] <= gnt1;
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rr_last_q <= 1'b1;
      rsp_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rr_last_q <= rr_last_d;
      rsp_err_q <= rsp_err_d;
    end
  end

endmodule
